// File: rtl/cache_pkg.sv
// Shared types and address helpers for the set-associative cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  localparam int WORD_SEL_BIT = 2;
  localparam int LINE_W       = 64;

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Tree PLRU needs ways-1 bits; a direct-mapped cache keeps a dummy bit.
  function automatic int plru_bits(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int set_bits);
    return (addr >> 3) & ((32'd1 << set_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int set_bits,
                                          input int tag_w);
    return (addr >> (3 + set_bits)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_controller_assoc_if.sv
// Requester and SRAM-side signals of cache_controller_assoc; CACHE_STATS_EN adds counters.
interface cache_controller_assoc_if;
  logic [31:0] address_bus_in;
  logic [31:0] write_data_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] read_data_out;
  logic        ready_out;
  logic [63:0] sram_read_data_in;
  logic        sram_ready_in;
  logic [31:0] sram_addr_out;
  logic [31:0] sram_write_data_out;
  logic        sram_r_en_out;
  logic        sram_w_en_out;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;
`endif

  modport slave (
    input  address_bus_in, write_data_in, mem_r_en_in, mem_w_en_in,
    input  sram_read_data_in, sram_ready_in,
    output read_data_out, ready_out, sram_addr_out, sram_write_data_out,
    output sram_r_en_out, sram_w_en_out
`ifdef CACHE_STATS_EN
    , output hit_count_out, miss_count_out
`endif
  );

  modport master (
    output address_bus_in, write_data_in, mem_r_en_in, mem_w_en_in,
    output sram_read_data_in, sram_ready_in,
    input  read_data_out, ready_out, sram_addr_out, sram_write_data_out,
    input  sram_r_en_out, sram_w_en_out
`ifdef CACHE_STATS_EN
    , input hit_count_out, miss_count_out
`endif
  );
endinterface

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set: picks the fill victim (invalid way first) and
// computes the post-access tree bits. Purely combinational, no backpressure.
module cache_plru
  import cache_pkg::*;
#(
  parameter  int WAYS   = 2,
  localparam int WAY_W  = way_bits(WAYS),
  localparam int PLRU_W = plru_bits(WAYS)
) (
  input  logic [PLRU_W-1:0] plru_in,
  input  logic [WAY_W-1:0]  access_way,
  input  logic [WAYS-1:0]   valid_in,
  output logic [WAY_W-1:0]  victim,
  output logic [PLRU_W-1:0] plru_out
);

  logic [WAY_W-1:0]  tree_victim;
  logic [PLRU_W-1:0] plru_next;

  // Bits always point toward the way to evict next, i.e. away from the last access.
  if (WAYS == 4) begin : g_four
    always_comb begin
      tree_victim  = plru_in[0] ? {1'b1, plru_in[2]} : {1'b0, plru_in[1]};
      plru_next    = plru_in;
      plru_next[0] = ~access_way[1];
      if (access_way[1]) plru_next[2] = ~access_way[0];
      else               plru_next[1] = ~access_way[0];
    end
  end else if (WAYS == 2) begin : g_two
    assign tree_victim = plru_in;
    assign plru_next   = ~access_way;
  end else begin : g_one
    assign tree_victim = '0;
    assign plru_next   = plru_in;
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    victim = tree_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_in[w]) victim = WAY_W'(w);
    end
  end

  assign plru_out = plru_next;

endmodule

// File: rtl/cache_controller_assoc.sv
// N-way write-through/no-allocate cache; read hits complete in the request cycle,
// misses and writes stall via ready_out until the SRAM pulse. Optional CACHE_STATS_EN.
module cache_controller_assoc
  import cache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 6,
  parameter int TAG_W    = 10
) (
  input logic                      clk,
  input logic                      rst,
  cache_controller_assoc_if.slave  bus
);

  localparam int SETS   = 2 ** SET_BITS;
  localparam int WAY_W  = way_bits(WAYS);
  localparam int PLRU_W = plru_bits(WAYS);

  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [LINE_W-1:0] data_mem  [WAYS][SETS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [PLRU_W-1:0] plru_mem  [SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                word_sel;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [LINE_W-1:0]   hit_line;
  logic [WAY_W-1:0]    victim;
  logic [WAY_W-1:0]    access_way;
  logic [PLRU_W-1:0]   plru_next;
  logic                rd_hit_evt;
  logic                fill_evt;
  logic                wr_done;

  assign idx      = SET_BITS'(get_index(bus.address_bus_in, SET_BITS));
  assign tag      = TAG_W'(get_tag(bus.address_bus_in, SET_BITS, TAG_W));
  assign word_sel = bus.address_bus_in[WORD_SEL_BIT];

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[idx][w] && (tag_mem[w][idx] == tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_line = data_mem[w][idx];
      end
    end
  end

  assign rd_hit_evt = (state == IDLE) && !bus.mem_w_en_in && bus.mem_r_en_in && hit;
  assign fill_evt   = (state == RD_MISS) && bus.sram_ready_in;
  assign wr_done    = (state == WR_THRU) && bus.sram_ready_in;
  assign access_way = (state == RD_MISS) ? victim : hit_way;

  cache_plru #(.WAYS(WAYS)) u_plru (
    .plru_in    (plru_mem[idx]),
    .access_way (access_way),
    .valid_in   (valid_mem[idx]),
    .victim     (victim),
    .plru_out   (plru_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        plru_mem[s]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (fill_evt) valid_mem[idx][victim] <= 1'b1;
      if (rd_hit_evt || fill_evt || (wr_done && hit)) plru_mem[idx] <= plru_next;
    end
  end

  // Tag/data contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_evt) begin
      tag_mem[victim][idx]  <= tag;
      data_mem[victim][idx] <= bus.sram_read_data_in;
    end else if (wr_done && hit) begin
      if (word_sel) data_mem[hit_way][idx][63:32] <= bus.write_data_in;
      else          data_mem[hit_way][idx][31:0]  <= bus.write_data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.mem_w_en_in)                  state_nxt = WR_THRU;
        else if (bus.mem_r_en_in && !hit)     state_nxt = RD_MISS;
      end
      RD_MISS: if (bus.sram_ready_in)         state_nxt = IDLE;
      WR_THRU: if (bus.sram_ready_in)         state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_out           = 1'b0;
    bus.read_data_out       = '0;
    bus.sram_r_en_out       = 1'b0;
    bus.sram_w_en_out       = 1'b0;
    bus.sram_addr_out       = '0;
    bus.sram_write_data_out = '0;
    case (state)
      IDLE: begin
        if (rd_hit_evt) begin
          bus.ready_out     = 1'b1;
          bus.read_data_out = word_sel ? hit_line[63:32] : hit_line[31:0];
        end
      end
      RD_MISS: begin
        bus.sram_r_en_out = 1'b1;
        bus.sram_addr_out = {bus.address_bus_in[31:3], 3'b000};
        if (bus.sram_ready_in) begin
          bus.ready_out     = 1'b1;
          bus.read_data_out = word_sel ? bus.sram_read_data_in[63:32]
                                       : bus.sram_read_data_in[31:0];
        end
      end
      WR_THRU: begin
        bus.sram_w_en_out       = 1'b1;
        bus.sram_addr_out       = bus.address_bus_in;
        bus.sram_write_data_out = bus.write_data_in;
        bus.ready_out           = bus.sram_ready_in;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rd_hit_evt && (hit_cnt != '1))  hit_cnt  <= hit_cnt + 32'd1;
      if (fill_evt && (miss_cnt != '1))   miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count_out  = hit_cnt;
  assign bus.miss_count_out = miss_cnt;
`endif

endmodule

// File: tb/tb_cache_controller_assoc.sv
// Directed bench: a 2-way and a 4-way instance share stimulus; sel picks the active one.
module tb_cache_controller_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        r_en, w_en;
  logic [63:0] sram_line;
  logic        sram_rdy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_controller_assoc_if i2 ();
  cache_controller_assoc_if i4 ();

  assign i2.address_bus_in    = addr;
  assign i2.write_data_in     = wdata;
  assign i2.mem_r_en_in       = r_en & ~sel;
  assign i2.mem_w_en_in       = w_en & ~sel;
  assign i2.sram_read_data_in = sram_line;
  assign i2.sram_ready_in     = sram_rdy & ~sel;

  assign i4.address_bus_in    = addr;
  assign i4.write_data_in     = wdata;
  assign i4.mem_r_en_in       = r_en & sel;
  assign i4.mem_w_en_in       = w_en & sel;
  assign i4.sram_read_data_in = sram_line;
  assign i4.sram_ready_in     = sram_rdy & sel;

  cache_controller_assoc #(.WAYS(2), .SET_BITS(6), .TAG_W(10)) dut2 (
    .clk (clk), .rst (rst), .bus (i2));
  cache_controller_assoc #(.WAYS(4), .SET_BITS(6), .TAG_W(10)) dut4 (
    .clk (clk), .rst (rst), .bus (i4));

  logic        rdy, s_r_en, s_w_en;
  logic [31:0] rdata, s_addr, s_wdata;
  assign rdy     = sel ? i4.ready_out           : i2.ready_out;
  assign rdata   = sel ? i4.read_data_out       : i2.read_data_out;
  assign s_r_en  = sel ? i4.sram_r_en_out       : i2.sram_r_en_out;
  assign s_w_en  = sel ? i4.sram_w_en_out       : i2.sram_w_en_out;
  assign s_addr  = sel ? i4.sram_addr_out       : i2.sram_addr_out;
  assign s_wdata = sel ? i4.sram_write_data_out : i2.sram_write_data_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [31:0] a);
    return {32'hB000_0000 | a, 32'hA000_0000 | a};
  endfunction

  task automatic rd(input string tag, input logic [31:0] a, input bit exp_hit,
                    input logic [31:0] exp_d, input logic [63:0] line);
    @(posedge clk); #1;
    addr = a; r_en = 1'b1;
    @(negedge clk);
    if (exp_hit) begin
      chk({tag, "_hit_rdy"}, rdy, 64'd1);
      chk({tag, "_hit_data"}, rdata, exp_d);
      chk({tag, "_hit_no_sram"}, s_r_en, 64'd0);
    end else begin
      chk({tag, "_idle_rdy"}, rdy, 64'd0);
      @(negedge clk);
      chk({tag, "_miss_ren"}, s_r_en, 64'd1);
      chk({tag, "_miss_addr"}, s_addr, {a[31:3], 3'b000});
      chk({tag, "_miss_wait"}, rdy, 64'd0);
      @(posedge clk); #1;
      sram_line = line; sram_rdy = 1'b1;
      @(negedge clk);
      chk({tag, "_fill_rdy"}, rdy, 64'd1);
      chk({tag, "_fill_data"}, rdata, exp_d);
    end
    @(posedge clk); #1;
    r_en = 1'b0; sram_rdy = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; w_en = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, rdy, 64'd0);
    @(negedge clk);
    chk({tag, "_wen"}, s_w_en, 64'd1);
    chk({tag, "_ren_off"}, s_r_en, 64'd0);
    chk({tag, "_addr"}, s_addr, a);
    chk({tag, "_wdata"}, s_wdata, d);
    @(posedge clk); #1;
    sram_rdy = 1'b1;
    @(negedge clk);
    chk({tag, "_done_rdy"}, rdy, 64'd1);
    @(posedge clk); #1;
    w_en = 1'b0; sram_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; addr = '0; wdata = '0; r_en = 1'b0; w_en = 1'b0;
    sram_line = '0; sram_rdy = 1'b0;
    #3;
    chk("rst_rdy", rdy, 64'd0);
    chk("rst_ren", s_r_en, 64'd0);
    chk("rst_wen", s_w_en, 64'd0);
    chk("rst_addr", s_addr, 64'd0);
    chk("rst_wdata", s_wdata, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-way instance: fill, hit, write-through hit update, no-allocate write.
    rd("w2_rd0", 32'h0000, 1'b0, 32'hF0F0_F0F0, 64'hFFFF_FFFF_F0F0_F0F0);
    rd("w2_rd4", 32'h0004, 1'b1, 32'hFFFF_FFFF, 64'd0);
    wr("w2_wr4", 32'h0004, 32'hAAAA_AAAA);
    rd("w2_rd4b", 32'h0004, 1'b1, 32'hAAAA_AAAA, 64'd0);
    wr("w2_wrA00", 32'h0A00, 32'h1234_5678);
    rd("w2_rdA00", 32'h0A00, 1'b0, 32'h1234_5678, 64'h9999_0000_1234_5678);
    rd("w2_rd0b", 32'h0000, 1'b1, 32'hF0F0_F0F0, 64'd0);
`ifdef CACHE_STATS_EN
    chk("w2_hit_count", i2.hit_count_out, 64'd3);
    chk("w2_miss_count", i2.miss_count_out, 64'd2);
`endif
    // Way 0 was touched last, so the 0xC00 fill must evict 0xA00 in way 1.
    rd("w2_rdC00", 32'h0C00, 1'b0, 32'hA000_0C00, line_of(32'h0C00));
    rd("w2_rd0c", 32'h0000, 1'b1, 32'hF0F0_F0F0, 64'd0);
    rd("w2_rdA00b", 32'h0A00, 1'b0, 32'hA000_0A00, line_of(32'h0A00));

    // Four-way instance, set 0: fill ways 0..3, hit way 0, then 0x800 evicts way 2.
    sel = 1'b1;
    rd("w4_000", 32'h0000, 1'b0, 32'hA000_0000, line_of(32'h0000));
    rd("w4_200", 32'h0200, 1'b0, 32'hA000_0200, line_of(32'h0200));
    rd("w4_400", 32'h0400, 1'b0, 32'hA000_0400, line_of(32'h0400));
    rd("w4_600", 32'h0600, 1'b0, 32'hA000_0600, line_of(32'h0600));
    rd("w4_000h", 32'h0000, 1'b1, 32'hA000_0000, 64'd0);
    rd("w4_800", 32'h0800, 1'b0, 32'hA000_0800, line_of(32'h0800));
    rd("w4_400m", 32'h0400, 1'b0, 32'hA000_0400, line_of(32'h0400));
    // The 0x400 refill lands in way 1, leaving ways 0, 2 and 3 resident.
    rd("w4_000h2", 32'h0000, 1'b1, 32'hA000_0000, 64'd0);
    rd("w4_600h", 32'h0600, 1'b1, 32'hA000_0600, 64'd0);
    rd("w4_800h", 32'h0800, 1'b1, 32'hA000_0800, 64'd0);

    // Reset in the middle of a miss on the two-way instance.
    sel = 1'b0;
    @(posedge clk); #1;
    addr = 32'h0100; r_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_ren_before", s_r_en, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ren_drop", s_r_en, 64'd0);
    chk("mid_rst_rdy", rdy, 64'd0);
    @(posedge clk); #1;
    chk("mid_rst_ren_hold", s_r_en, 64'd0);
    r_en = 1'b0; rst = 1'b0;
    rd("post_rst_rd0", 32'h0000, 1'b0, 32'hF0F0_F0F0, 64'hFFFF_FFFF_F0F0_F0F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
